// File: rtl/nubus_pkg.sv
// Shared types and helpers for the NuBus transaction tracker: FSM states,
// status encodings and block-length decoding.
package nubus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BLOCK  = 2'd2
  } txn_state_e;

  // {tm1, tm0} reported when the watchdog forces completion
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  // {tm0, ad[1:0]} in true polarity that marks a block transfer
  localparam logic [2:0] MODE_BLOCK = 3'b001;

  // Block length from true-polarity ad[5:2]; 0 means an illegal code
  function automatic logic [4:0] blk_len(input logic [3:0] code);
    logic [4:0] len;
    casez (code)
      4'b???1: len = 5'd2;
      4'b??10: len = 5'd4;
      4'b?100: len = 5'd8;
      4'b1000: len = 5'd16;
      default: len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/nubus_sel_decode.sv
// Maps the address-phase transfer mode and low address bits onto Wishbone
// byte selects (lane 3 = ad[7:0] = sel[0]) and flags block transfers.
module nubus_sel_decode
  import nubus_pkg::*;
(
  input  logic       tm1n,
  input  logic       tm0n,
  input  logic [1:0] adn_lo,
  output logic [3:0] sel,
  output logic       block
);

  logic [2:0] mode_s;
  logic [3:0] lanes_s;

  assign mode_s = {~tm0n, ~adn_lo};

  // Lane pattern for each mode; selects only apply to writes
  always_comb begin
    lanes_s = 4'b0000;
    block   = 1'b0;
    sel     = 4'b0000;
    case (mode_s)
      3'b000:     lanes_s = 4'b1000;
      MODE_BLOCK: begin
        lanes_s = 4'b1111;
        block   = 1'b1;
      end
      3'b010:     lanes_s = 4'b0010;
      3'b011:     lanes_s = 4'b0001;
      3'b100:     lanes_s = 4'b1100;
      3'b101:     lanes_s = 4'b0100;
      3'b110:     lanes_s = 4'b0011;
      3'b111:     lanes_s = 4'b1111;
      default:    lanes_s = 4'b0000;
    endcase
    if (!tm1n) begin
      sel = lanes_s;
    end else begin
      sel = 4'b0000;
    end
  end

endmodule

// File: rtl/nubus_txn_tracker.sv
// Two-stage NuBus sampler and transaction decoder: pins are registered on
// each falling edge, then an FSM decodes address phase, beats and completion.
module nubus_txn_tracker
  import nubus_pkg::*;
#(
  parameter int MAX_BEATS      = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SUPER_EN       = 1,
  parameter int BEAT_W         = 4
) (
  input  logic              nub_clkn,
  input  logic              nub_resetn,
  input  logic [3:0]        nub_idn,
  input  logic              nub_tm0n,
  input  logic              nub_tm1n,
  input  logic              nub_startn,
  input  logic              nub_ackn,
  input  logic [31:0]       nub_adn,
  output logic              txn_valid,
  output logic [31:0]       txn_addr,
  output logic              txn_write,
  output logic [3:0]        txn_sel,
  output logic              txn_block,
  output logic [BEAT_W:0]   txn_len,
  output logic              slot_hit,
  output logic              super_hit,
  output logic              beat_valid,
  output logic [BEAT_W-1:0] beat_idx,
  output logic [31:0]       beat_data,
  output logic              txn_done,
  output logic [1:0]        txn_status,
  output logic              txn_timeout,
  output logic              blk_err,
  output logic              busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       MAX_CODE = 5'(MAX_BEATS);
  localparam logic [BEAT_W:0]  MAX_LEN  = (BEAT_W+1)'(MAX_BEATS);

  logic              startn_r, ackn_r, tm0n_r, tm1n_r;
  logic [31:0]       adn_r;
  logic              start_s, ack_s, tm0_s, tm1_s;
  logic [31:0]       ad_s;
  logic [3:0]        sel_s;
  logic              block_s;
  logic [4:0]        code_len_s;
  logic              len_err_s;
  logic [BEAT_W:0]   len_new_s;

  txn_state_e        state_r, state_nxt_s;
  logic [WD_W-1:0]   wd_r, wd_nxt_s;
  logic [BEAT_W-1:0] beat_cnt_r, beat_cnt_nxt_s, last_idx_r, last_idx_nxt_s;

  logic              valid_nxt_s, write_nxt_s, block_nxt_s, slot_nxt_s, super_nxt_s;
  logic [31:0]       addr_nxt_s, beat_data_nxt_s;
  logic [3:0]        sel_nxt_s;
  logic [BEAT_W:0]   len_nxt_s;
  logic              beat_valid_nxt_s, done_nxt_s, timeout_nxt_s, blk_err_nxt_s;
  logic [BEAT_W-1:0] beat_idx_nxt_s;
  logic [1:0]        status_nxt_s;

  // Stage 1: raw pin sampling, reset to an idle bus
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      startn_r <= 1'b1;
      ackn_r   <= 1'b1;
      tm0n_r   <= 1'b1;
      tm1n_r   <= 1'b1;
      adn_r    <= 32'h0000_0000;
    end else begin
      startn_r <= nub_startn;
      ackn_r   <= nub_ackn;
      tm0n_r   <= nub_tm0n;
      tm1n_r   <= nub_tm1n;
      adn_r    <= nub_adn;
    end
  end

  assign start_s = ~startn_r;
  assign ack_s   = ~ackn_r;
  assign tm0_s   = ~tm0n_r;
  assign tm1_s   = ~tm1n_r;
  assign ad_s    = ~adn_r;

  nubus_sel_decode u_sel_decode (
    .tm1n   (tm1n_r),
    .tm0n   (tm0n_r),
    .adn_lo (adn_r[1:0]),
    .sel    (sel_s),
    .block  (block_s)
  );

  assign code_len_s = blk_len(ad_s[5:2]);
  assign len_err_s  = (code_len_s == 5'd0) || (code_len_s > MAX_CODE);
  assign len_new_s  = !block_s ? (BEAT_W+1)'(1) :
                      (len_err_s ? MAX_LEN : (BEAT_W+1)'(code_len_s));

  // Next-state and next-output decode; fields hold unless an event updates them
  always_comb begin
    state_nxt_s      = state_r;
    wd_nxt_s         = wd_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    last_idx_nxt_s   = last_idx_r;
    valid_nxt_s      = 1'b0;
    addr_nxt_s       = txn_addr;
    write_nxt_s      = txn_write;
    sel_nxt_s        = txn_sel;
    block_nxt_s      = txn_block;
    len_nxt_s        = txn_len;
    slot_nxt_s       = slot_hit;
    super_nxt_s      = super_hit;
    beat_valid_nxt_s = 1'b0;
    beat_idx_nxt_s   = beat_idx;
    beat_data_nxt_s  = beat_data;
    done_nxt_s       = 1'b0;
    status_nxt_s     = txn_status;
    timeout_nxt_s    = txn_timeout;
    blk_err_nxt_s    = blk_err;
    case (state_r)
      ST_IDLE: begin
        // START together with ACK is an attention cycle and is not a transaction
        if (start_s && !ack_s) begin
          valid_nxt_s    = 1'b1;
          addr_nxt_s     = ad_s;
          write_nxt_s    = tm1_s;
          sel_nxt_s      = sel_s;
          block_nxt_s    = block_s;
          len_nxt_s      = len_new_s;
          slot_nxt_s     = (ad_s[31:24] == {4'hF, ~nub_idn});
          super_nxt_s    = (SUPER_EN != 0) && (ad_s[31:28] == ~nub_idn);
          status_nxt_s   = 2'b00;
          timeout_nxt_s  = 1'b0;
          blk_err_nxt_s  = block_s && len_err_s;
          wd_nxt_s       = {WD_W{1'b0}};
          beat_cnt_nxt_s = {BEAT_W{1'b0}};
          last_idx_nxt_s = len_new_s[BEAT_W-1:0] - BEAT_W'(1);
          state_nxt_s    = block_s ? ST_BLOCK : ST_SINGLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SINGLE, ST_BLOCK: begin
        // ACK is checked first so it wins over a watchdog expiry on the same edge
        if (ack_s) begin
          beat_valid_nxt_s = 1'b1;
          beat_idx_nxt_s   = beat_cnt_r;
          beat_data_nxt_s  = ad_s;
          done_nxt_s       = 1'b1;
          status_nxt_s     = {tm1_s, tm0_s};
          timeout_nxt_s    = 1'b0;
          if (beat_cnt_r != last_idx_r) begin
            blk_err_nxt_s = 1'b1;
          end else begin
            blk_err_nxt_s = blk_err;
          end
          state_nxt_s = ST_IDLE;
        end else if ((state_r == ST_BLOCK) && tm0_s) begin
          beat_valid_nxt_s = 1'b1;
          beat_idx_nxt_s   = beat_cnt_r;
          beat_data_nxt_s  = ad_s;
          wd_nxt_s         = {WD_W{1'b0}};
          if (beat_cnt_r == last_idx_r) begin
            blk_err_nxt_s = 1'b1;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1);
          end
        end else if (wd_r == WD_LAST) begin
          done_nxt_s    = 1'b1;
          timeout_nxt_s = 1'b1;
          status_nxt_s  = STATUS_TIMEOUT;
          state_nxt_s   = ST_IDLE;
        end else begin
          wd_nxt_s = wd_r + WD_W'(1);
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Stage 2: FSM state, watchdog and registered outputs
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_r     <= ST_IDLE;
      wd_r        <= {WD_W{1'b0}};
      beat_cnt_r  <= {BEAT_W{1'b0}};
      last_idx_r  <= {BEAT_W{1'b0}};
      txn_valid   <= 1'b0;
      txn_addr    <= 32'h0000_0000;
      txn_write   <= 1'b0;
      txn_sel     <= 4'b0000;
      txn_block   <= 1'b0;
      txn_len     <= {(BEAT_W+1){1'b0}};
      slot_hit    <= 1'b0;
      super_hit   <= 1'b0;
      beat_valid  <= 1'b0;
      beat_idx    <= {BEAT_W{1'b0}};
      beat_data   <= 32'h0000_0000;
      txn_done    <= 1'b0;
      txn_status  <= 2'b00;
      txn_timeout <= 1'b0;
      blk_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wd_r        <= wd_nxt_s;
      beat_cnt_r  <= beat_cnt_nxt_s;
      last_idx_r  <= last_idx_nxt_s;
      txn_valid   <= valid_nxt_s;
      txn_addr    <= addr_nxt_s;
      txn_write   <= write_nxt_s;
      txn_sel     <= sel_nxt_s;
      txn_block   <= block_nxt_s;
      txn_len     <= len_nxt_s;
      slot_hit    <= slot_nxt_s;
      super_hit   <= super_nxt_s;
      beat_valid  <= beat_valid_nxt_s;
      beat_idx    <= beat_idx_nxt_s;
      beat_data   <= beat_data_nxt_s;
      txn_done    <= done_nxt_s;
      txn_status  <= status_nxt_s;
      txn_timeout <= timeout_nxt_s;
      blk_err     <= blk_err_nxt_s;
      busy        <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_nubus_txn_tracker.sv
// Directed bench for nubus_txn_tracker: single/block transfers, overrun,
// bad length code, watchdog expiry and ACK-vs-expiry, async reset mid-block.
module tb_nubus_txn_tracker;

  logic        nub_clkn, nub_resetn;
  logic [3:0]  nub_idn;
  logic        nub_tm0n, nub_tm1n, nub_startn, nub_ackn;
  logic [31:0] nub_adn;
  logic        txn_valid, txn_write, txn_block, slot_hit, super_hit;
  logic [31:0] txn_addr, beat_data;
  logic [3:0]  txn_sel;
  logic [4:0]  txn_len;
  logic        beat_valid, txn_done, txn_timeout, blk_err, busy;
  logic [3:0]  beat_idx;
  logic [1:0]  txn_status;

  int n_cmp = 0;
  int n_err = 0;

  nubus_txn_tracker #(
    .MAX_BEATS(16), .TIMEOUT_CYCLES(255), .SUPER_EN(1), .BEAT_W(4)
  ) dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .nub_idn(nub_idn),
    .nub_tm0n(nub_tm0n), .nub_tm1n(nub_tm1n), .nub_startn(nub_startn),
    .nub_ackn(nub_ackn), .nub_adn(nub_adn),
    .txn_valid(txn_valid), .txn_addr(txn_addr), .txn_write(txn_write),
    .txn_sel(txn_sel), .txn_block(txn_block), .txn_len(txn_len),
    .slot_hit(slot_hit), .super_hit(super_hit), .beat_valid(beat_valid),
    .beat_idx(beat_idx), .beat_data(beat_data), .txn_done(txn_done),
    .txn_status(txn_status), .txn_timeout(txn_timeout), .blk_err(blk_err),
    .busy(busy)
  );

  initial nub_clkn = 1'b1;
  always #10 nub_clkn = ~nub_clkn;

  task automatic tick();
    @(negedge nub_clkn);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive the bus in true polarity
  task automatic drive(input logic start, input logic ack, input logic tm1,
                       input logic tm0, input logic [31:0] ad);
    nub_startn = ~start;
    nub_ackn   = ~ack;
    nub_tm1n   = ~tm1;
    nub_tm0n   = ~tm0;
    nub_adn    = ~ad;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
  endtask

  // One-cycle bus event, then idle; returns where its outputs are visible
  task automatic bus_cycle(input logic start, input logic ack, input logic tm1,
                           input logic tm0, input logic [31:0] ad);
    drive(start, ack, tm1, tm0, ad);
    tick();
    idle();
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nub_resetn = 1'b0;
    nub_idn    = 4'h6;
    idle();
    step(2);
    chk("rst_valid", txn_valid, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_addr", txn_addr, 32'd0);
    chk("rst_len", txn_len, 32'd0);
    chk("rst_data", beat_data, 32'd0);
    nub_resetn = 1'b1;
    tick();

    // single word write to slot 9
    bus_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hF900_0003);
    chk("t1_valid", txn_valid, 32'd1);
    chk("t1_addr", txn_addr, 32'hF900_0003);
    chk("t1_write", txn_write, 32'd1);
    chk("t1_sel", txn_sel, 32'hF);
    chk("t1_block", txn_block, 32'd0);
    chk("t1_len", txn_len, 32'd1);
    chk("t1_slot", slot_hit, 32'd1);
    chk("t1_super", super_hit, 32'd0);
    chk("t1_busy", busy, 32'd1);
    tick();
    chk("t1_valid_pulse", txn_valid, 32'd0);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    chk("t1_done", txn_done, 32'd1);
    chk("t1_beat", beat_valid, 32'd1);
    chk("t1_idx", beat_idx, 32'd0);
    chk("t1_data", beat_data, 32'h1234_5678);
    chk("t1_status", txn_status, 32'd0);
    chk("t1_timeout", txn_timeout, 32'd0);
    chk("t1_idle", busy, 32'd0);
    tick();
    chk("t1_done_pulse", txn_done, 32'd0);
    chk("t1_data_hold", beat_data, 32'h1234_5678);

    // single byte-2 read, ACK after 3 idle cycles
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hF900_0002);
    chk("t2_valid", txn_valid, 32'd1);
    chk("t2_write", txn_write, 32'd0);
    chk("t2_sel", txn_sel, 32'd0);
    step(3);
    chk("t2_wait", txn_done, 32'd0);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F);
    chk("t2_done", txn_done, 32'd1);
    chk("t2_idx", beat_idx, 32'd0);
    chk("t2_data", beat_data, 32'hA5A5_0F0F);
    chk("t2_status", txn_status, 32'd0);

    // attention cycle is ignored
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hF900_0003);
    chk("attn_valid", txn_valid, 32'd0);
    chk("attn_busy", busy, 32'd0);

    // block read of 8 in superslot 9
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h9000_0011);
    chk("t3_valid", txn_valid, 32'd1);
    chk("t3_block", txn_block, 32'd1);
    chk("t3_len", txn_len, 32'd8);
    chk("t3_super", super_hit, 32'd1);
    chk("t3_slot", slot_hit, 32'd0);
    chk("t3_blkerr", blk_err, 32'd0);
    for (int i = 0; i < 7; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0000 + i);
      chk("t3_beat", beat_valid, 32'd1);
      chk("t3_idx", beat_idx, i);
      chk("t3_bdata", beat_data, 32'hB000_0000 + i);
    end
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hF900_0003);
    chk("t3_start_busy", txn_valid, 32'd0);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hB000_0007);
    chk("t3_done", txn_done, 32'd1);
    chk("t3_last_idx", beat_idx, 32'd7);
    chk("t3_last_data", beat_data, 32'hB000_0007);
    chk("t3_end_err", blk_err, 32'd0);

    // block write of 4 overrun by 6 intermediates
    bus_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'hF900_0009);
    chk("t4_len", txn_len, 32'd4);
    chk("t4_sel", txn_sel, 32'hF);
    chk("t4_block", txn_block, 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hC000_0000 + i);
      chk("t4_beat", beat_valid, 32'd1);
      chk("t4_idx", beat_idx, (i < 3) ? i : 3);
      chk("t4_err", blk_err, (i >= 3) ? 32'd1 : 32'd0);
    end
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hC000_0006);
    chk("t4_done", txn_done, 32'd1);
    chk("t4_final_idx", beat_idx, 32'd3);
    chk("t4_final_err", blk_err, 32'd1);

    // illegal length code 0000
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hF900_0001);
    chk("t5_len", txn_len, 32'd16);
    chk("t5_err", blk_err, 32'd1);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
    chk("t5_done", txn_done, 32'd1);

    // watchdog expiry
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hF900_0000);
    chk("t6_valid", txn_valid, 32'd1);
    chk("t6_err_clr", blk_err, 32'd0);
    step(254);
    chk("t6_early", txn_done, 32'd0);
    chk("t6_busy", busy, 32'd1);
    tick();
    chk("t6_done", txn_done, 32'd1);
    chk("t6_timeout", txn_timeout, 32'd1);
    chk("t6_status", txn_status, 32'd3);
    chk("t6_nobeat", beat_valid, 32'd0);
    chk("t6_idle", busy, 32'd0);

    // ACK on the expiry edge wins
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hF900_0000);
    chk("t7_valid", txn_valid, 32'd1);
    step(253);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hD00D_F00D);
    tick();
    chk("t7_early", txn_done, 32'd0);
    idle();
    tick();
    chk("t7_done", txn_done, 32'd1);
    chk("t7_timeout", txn_timeout, 32'd0);
    chk("t7_status", txn_status, 32'd0);
    chk("t7_data", beat_data, 32'hD00D_F00D);

    // async reset in the middle of a block
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hF900_0011);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hE000_0000);
    chk("t8_beat", beat_valid, 32'd1);
    #2 nub_resetn = 1'b0;
    #1;
    chk("t8_busy", busy, 32'd0);
    chk("t8_beat_clr", beat_valid, 32'd0);
    chk("t8_addr", txn_addr, 32'd0);
    chk("t8_data", beat_data, 32'd0);
    chk("t8_len", txn_len, 32'd0);
    #2 nub_resetn = 1'b1;
    bus_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hF900_0003);
    chk("t8_valid", txn_valid, 32'd1);
    chk("t8_new_addr", txn_addr, 32'hF900_0003);
    chk("t8_no_done", txn_done, 32'd0);
    chk("t8_new_busy", busy, 32'd1);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
    chk("t8_done", txn_done, 32'd1);
    chk("t8_done_idx", beat_idx, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
